// File: rtl/pc_gen.sv
// pc_gen: next-PC generator with fixed-priority redirects, stall buffering and a registered fetch PC.
// Optional PC_ALIGN_CHECK_EN adds pc_misalign for redirect targets with pc[1:0] != 0.
module pc_gen #(
  parameter int              NUM_SRC     = 5,
  parameter int              PC_W        = 32,
  parameter int              FETCH_WIDTH = 2,
  parameter logic [PC_W-1:0] RESET_PC    = 32'hbfc0_0000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_SRC-1:0]         redirect_valid,
  input  logic [NUM_SRC*PC_W-1:0]    redirect_pc,
  input  logic                       pc_ready,
  output logic                       pc_valid,
  output logic [PC_W-1:0]            pc,
  output logic                       pc_redirected,
  output logic [$clog2(NUM_SRC)-1:0] pc_src,
  output logic                       pending
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic                       pc_misalign
`endif
);
  localparam int SW = $clog2(NUM_SRC);
  localparam int B  = FETCH_WIDTH * 4;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pend_pc_q, pend_pc_d, tgt, seq;
  logic [SW-1:0] src_q, src_d, pend_src_q, pend_src_d, sel;
  logic redir_q, redir_d, pending_q, pending_d;
  logic any_redir, fire, take_r, buf_r, take_p, take_s;
  always_comb begin
    sel = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (redirect_valid[i]) sel = SW'(i);
  end
  assign any_redir = |redirect_valid;
  assign tgt       = redirect_pc[sel*PC_W +: PC_W];
  assign seq       = (pc_q & ~PC_W'(B - 1)) + PC_W'(B);
  assign pc_valid  = state_q == RUN;
  assign fire      = pc_valid & pc_ready;
  // A stalled pc_valid blocks loading; IDLE (no valid pc yet) loads a redirect directly.
  assign take_r = any_redir & (fire | ~pc_valid);
  assign buf_r  = any_redir & ~take_r;
  assign take_p = ~any_redir & fire & pending_q;
  assign take_s = ~any_redir & fire & ~pending_q;
  always_comb begin
    state_d    = RUN;
    pc_d       = take_r ? tgt : take_p ? pend_pc_q : take_s ? seq : pc_q;
    redir_d    = (take_r | take_p) ? 1'b1 : take_s ? 1'b0 : redir_q;
    src_d      = take_r ? sel : take_p ? pend_src_q : take_s ? '0 : src_q;
    pending_d  = buf_r | (pending_q & ~take_r & ~take_p);
    pend_pc_d  = buf_r ? tgt : pend_pc_q;
    pend_src_d = buf_r ? sel : pend_src_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      redir_q    <= 1'b0;
      src_q      <= '0;
      pending_q  <= 1'b0;
      pend_pc_q  <= '0;
      pend_src_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redir_q    <= redir_d;
      src_q      <= src_d;
      pending_q  <= pending_d;
      pend_pc_q  <= pend_pc_d;
      pend_src_q <= pend_src_d;
    end
  end
  assign pc            = pc_q;
  assign pc_redirected = redir_q;
  assign pc_src        = src_q;
  assign pending       = pending_q;
`ifdef PC_ALIGN_CHECK_EN
  logic mis_q, mis_d, pmis_q, pmis_d;
  always_comb begin
    mis_d  = take_r ? |tgt[1:0] : take_p ? pmis_q : take_s ? 1'b0 : mis_q;
    pmis_d = buf_r ? |tgt[1:0] : pmis_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mis_q  <= 1'b0;
      pmis_q <= 1'b0;
    end else begin
      mis_q  <= mis_d;
      pmis_q <= pmis_d;
    end
  end
  assign pc_misalign = mis_q;
`endif
endmodule
